// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC conversion scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam int unsigned DEF_SAMPLE_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  // Channel index width; a single channel still needs one select bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the channel after 'last'.
module rr_arbiter
  import adc_sched_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]          req,
  input  logic [idx_w(N_CH)-1:0]   last,
  output logic [N_CH-1:0]          grant_c,
  output logic [idx_w(N_CH)-1:0]   idx_c,
  output logic                     valid_c
);

  localparam int unsigned IDX_W = idx_w(N_CH);

  int unsigned w_pos;

  // First requester found after 'last' (wrapping) wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    w_pos   = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      w_pos = (32'(last) + i) % N_CH;
      if (!valid_c && req[IDX_W'(w_pos)]) begin
        valid_c               = 1'b1;
        idx_c                 = IDX_W'(w_pos);
        grant_c[IDX_W'(w_pos)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Shares one SAR ADC among N_CH requesters: arbitrate, track, convert, respond.
// Optional conversion timeout with error reporting: define ADC_SCHED_TIMEOUT_EN.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned N_BITS         = 10,
  parameter int unsigned SAMPLE_CYCLES  = DEF_SAMPLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         grant,
  output logic [idx_w(N_CH)-1:0]  adc_sel,
  output logic                    adc_hold,
  input  logic                    adc_eoc,
  input  logic [N_BITS-1:0]       adc_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N_BITS-1:0]       rsp_data,
  output logic [idx_w(N_CH)-1:0]  rsp_ch,
  output logic                    busy
`ifdef ADC_SCHED_TIMEOUT_EN
  ,
  output logic                    err_timeout,
  output logic [7:0]              err_count
`endif
);

  localparam int unsigned IDX_W   = idx_w(N_CH);
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_last;

  logic [N_CH-1:0]    w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;

  logic               w_sample_done;
  logic               w_eoc_hit;
  logic               w_timeout;
  logic               w_handshake;

  logic [N_CH-1:0]    w_grant_nxt;
  logic [IDX_W-1:0]   w_sel_nxt;
  logic               w_hold_nxt;
  logic               w_valid_nxt;
  logic [N_BITS-1:0]  w_data_nxt;
  logic [IDX_W-1:0]   w_ch_nxt;
  logic               w_busy_nxt;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (req),
    .last    (r_last),
    .grant_c (w_arb_grant),
    .idx_c   (w_arb_idx),
    .valid_c (w_arb_valid)
  );

  assign w_sample_done = (r_cnt == CNT_W'(SAMPLE_CYCLES - 1));
  assign w_eoc_hit     = (r_state == ST_CONVERT) && adc_eoc;
  assign w_handshake   = (r_state == ST_RESPOND) && rsp_ready;
`ifdef ADC_SCHED_TIMEOUT_EN
  assign w_timeout     = (r_state == ST_CONVERT) && !adc_eoc &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; eoc only matters in CONVERT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_arb_valid)   w_state_nxt = ST_SAMPLE;
      ST_SAMPLE:  if (w_sample_done) w_state_nxt = ST_CONVERT;
      ST_CONVERT: begin
        if (adc_eoc)        w_state_nxt = ST_RESPOND;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_RESPOND: if (rsp_ready)     w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Next output values; grant only changes on arbitration or release.
  always_comb begin
    w_grant_nxt = grant;
    w_sel_nxt   = adc_sel;
    w_data_nxt  = rsp_data;
    w_ch_nxt    = rsp_ch;
    w_hold_nxt  = (w_state_nxt == ST_CONVERT);
    w_valid_nxt = (w_state_nxt == ST_RESPOND);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    if (r_state == ST_IDLE && w_arb_valid) begin
      w_grant_nxt = w_arb_grant;
      w_sel_nxt   = w_arb_idx;
    end
    if (w_handshake || w_timeout) begin
      w_grant_nxt = '0;
    end
    if (w_eoc_hit) begin
      w_data_nxt = adc_result;
      w_ch_nxt   = adc_sel;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      adc_sel   <= '0;
      adc_hold  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ch    <= '0;
      busy      <= 1'b0;
    end else begin
      grant     <= w_grant_nxt;
      adc_sel   <= w_sel_nxt;
      adc_hold  <= w_hold_nxt;
      rsp_valid <= w_valid_nxt;
      rsp_data  <= w_data_nxt;
      rsp_ch    <= w_ch_nxt;
      busy      <= w_busy_nxt;
    end
  end

  // Phase counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (reset || (w_state_nxt != r_state)) r_cnt <= '0;
    else if (r_cnt != CNT_W'(CNT_MAX))    r_cnt <= r_cnt + CNT_W'(1);
  end

  // Round-robin pointer advances when a grant is released (served or aborted).
  always_ff @(posedge clk) begin
    if (reset)                         r_last <= IDX_W'(N_CH - 1);
    else if (w_handshake || w_timeout) r_last <= adc_sel;
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  // Abort pulse and saturating abort counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      err_timeout <= w_timeout;
      if (w_timeout && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler (defaults N_CH=4, N_BITS=10, SAMPLE=4, TIMEOUT=64).
module tb_adc_conv_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] adc_sel;
  logic       adc_hold;
  logic       adc_eoc;
  logic [9:0] adc_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [9:0] rsp_data;
  logic [1:0] rsp_ch;
  logic       busy;
`ifdef ADC_SCHED_TIMEOUT_EN
  logic       err_timeout;
  logic [7:0] err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adc_conv_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .adc_sel    (adc_sel),
    .adc_hold   (adc_hold),
    .adc_eoc    (adc_eoc),
    .adc_result (adc_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_ch     (rsp_ch),
    .busy       (busy)
`ifdef ADC_SCHED_TIMEOUT_EN
    ,
    .err_timeout(err_timeout),
    .err_count  (err_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (adc_hold === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_wait_hold: adc_hold never rose within 30 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; adc_eoc = 1'b0; adc_result = '0; rsp_ready = 1'b1;
    tick(); tick();
    n_tests++;
    if ({grant, adc_sel, adc_hold, rsp_valid, rsp_data, rsp_ch, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b sel=%0d hold=%b v=%b d=%h ch=%0d busy=%b, want all 0",
               grant, adc_sel, adc_hold, rsp_valid, rsp_data, rsp_ch, busy);
    end
`ifdef ADC_SCHED_TIMEOUT_EN
    n_tests++;
    if ({err_timeout, err_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_err: got to=%b cnt=%0d, want 0/0", err_timeout, err_count);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single();
    int first_valid;
    first_valid = -1;
    req = 4'b0100; rsp_ready = 1'b1; adc_result = 10'h1A5;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin
        req = '0;
        n_tests++;
        if (grant !== 4'b0100 || adc_sel !== 2'd2 || adc_hold !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_grant: got grant=%b sel=%0d hold=%b busy=%b, want 0100/2/0/1",
                   grant, adc_sel, adc_hold, busy);
        end
      end
      if (n == 4) begin
        n_tests++;
        if (adc_hold !== 1'b0) begin
          n_fail++;
          $display("FAIL single_sample_hold: got %b want 0", adc_hold);
        end
      end
      if (n == 5) begin
        n_tests++;
        if (adc_hold !== 1'b1) begin
          n_fail++;
          $display("FAIL single_convert_hold: got %b want 1", adc_hold);
        end
      end
      adc_eoc = (n == 10);
      if (rsp_valid === 1'b1) begin
        first_valid = n;
        break;
      end
    end
    adc_eoc = 1'b0;
    n_tests++;
    if (first_valid != 11) begin
      n_fail++;
      $display("FAIL single_latency: rsp_valid at cycle %0d, want 11", first_valid);
    end
    n_tests++;
    if (rsp_data !== 10'h1A5 || rsp_ch !== 2'd2 || adc_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got data=%h ch=%0d hold=%b, want 1a5/2/0", rsp_data, rsp_ch, adc_hold);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got v=%b grant=%b busy=%b, want 0/0000/0", rsp_valid, grant, busy);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_hold("fair");
      adc_result = 10'(k * 7 + 1);
      adc_eoc = 1'b1;
      tick();
      adc_eoc = 1'b0;
      exp_g = 4'b0001 << (k % 4);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_ch !== 2'(k % 4) || grant !== exp_g || rsp_data !== 10'(k * 7 + 1)) begin
        n_fail++;
        $display("FAIL fair_conv%0d: got v=%b ch=%0d grant=%b d=%h, want 1/%0d/%b/%h",
                 k, rsp_valid, rsp_ch, grant, rsp_data, k % 4, exp_g, 10'(k * 7 + 1));
      end
    end
    req = '0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req = 4'b1001;
    wait_hold("bp");
    adc_result = 10'h2C3; adc_eoc = 1'b1;
    tick();
    adc_eoc = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 10'h2C3 || rsp_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b d=%h ch=%0d, want 1/2c3/0", rsp_valid, rsp_data, rsp_ch);
    end
    adc_result = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      adc_eoc = (i % 2 == 0);
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 10'h2C3 || rsp_ch !== 2'd0 ||
          grant !== 4'b0001 || adc_hold !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got v=%b d=%h ch=%0d grant=%b hold=%b, want 1/2c3/0/0001/0",
                 i, rsp_valid, rsp_data, rsp_ch, grant, adc_hold);
      end
    end
    adc_eoc = 1'b0; req = '0; rsp_ready = 1'b1;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b grant=%b, want 0/0000", rsp_valid, grant);
    end
  endtask

  task automatic test_mid_reset();
    req = 4'b0100;
    wait_hold("mr");
    req = '0;
    reset = 1'b1;
    tick();
    n_tests++;
    if (adc_hold !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL mr_reset: got hold=%b v=%b busy=%b grant=%b, want 0/0/0/0000",
               adc_hold, rsp_valid, busy, grant);
    end
    reset = 1'b0;
    req = 4'b0001;
    tick();
    req = '0;
    n_tests++;
    if (grant !== 4'b0001 || adc_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mr_grant: got grant=%b sel=%0d, want 0001/0", grant, adc_sel);
    end
    wait_hold("mr2");
    adc_result = 10'h0F0; adc_eoc = 1'b1;
    tick();
    adc_eoc = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0 || rsp_data !== 10'h0F0) begin
      n_fail++;
      $display("FAIL mr_rsp: got v=%b ch=%0d d=%h, want 1/0/0f0", rsp_valid, rsp_ch, rsp_data);
    end
    tick();
  endtask

  task automatic test_req_drop();
    req = 4'b0010;
    tick();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_grant: got %b want 0010", grant);
    end
    tick();
    req = '0;
    wait_hold("drop");
    adc_result = 10'h055; adc_eoc = 1'b1;
    tick();
    adc_eoc = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 || rsp_data !== 10'h055) begin
      n_fail++;
      $display("FAIL drop_rsp: got v=%b ch=%0d d=%h, want 1/1/055", rsp_valid, rsp_ch, rsp_data);
    end
    tick();
  endtask

`ifdef ADC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    req = 4'b0001;
    tick();
    req = '0;
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL to_grant: got %b want 0001", grant);
    end
    wait_hold("to");
    for (int i = 1; i < 64; i++) tick();
    n_tests++;
    if (adc_hold !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_cycle64: got hold=%b to=%b, want 1/0", adc_hold, err_timeout);
    end
    tick();
    n_tests++;
    if (adc_hold !== 1'b0 || err_timeout !== 1'b1 || err_count !== 8'd1 ||
        busy !== 1'b0 || rsp_valid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_abort: got hold=%b to=%b cnt=%0d busy=%b v=%b grant=%b, want 0/1/1/0/0/0000",
               adc_hold, err_timeout, err_count, busy, rsp_valid, grant);
    end
    req = 4'b0011;
    tick();
    req = '0;
    n_tests++;
    if (err_timeout !== 1'b0 || grant !== 4'b0010 || adc_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL to_next: got to=%b grant=%b sel=%0d, want 0/0010/1", err_timeout, grant, adc_sel);
    end
    wait_hold("to2");
    adc_eoc = 1'b1;
    tick();
    adc_eoc = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    test_req_drop();
`ifdef ADC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
